// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter: shares one single-port video RAM between VGA scanout reads and
// buffered pixel writes. Scanout always wins; queued writes drain on cycles with no
// scan request, so scanout never stalls.
//
// Ports
//   Clock, Reset                   clock, synchronous active-high reset
//   iScanActive/iScanCol/iScanRow  scanout pixel request
//   oScanData/oScanDataValid       scanout pixel, 3 cycles after the request
//   iWrValid/iWrCol/iWrRow/iWrData write request, accepted when oWrReady is high
//   oWrReady                       write FIFO can accept
//   oWrDrop                        1-cycle pulse, out-of-range write discarded
//   oFifoLevel                     entries held in the write FIFO
//   oRamAddr/oRamWe/oRamWData      registered RAM controls, address = {row, col}
//   iRamRData                      RAM read data, 1 cycle after oRamAddr
module vga_vram_arbiter #(
    parameter int unsigned X_WIDTH    = 8,
    parameter int unsigned Y_WIDTH    = 8,
    parameter int unsigned X_SIZE     = 256,
    parameter int unsigned Y_SIZE     = 256,
    parameter int unsigned DATA_WIDTH = 3,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FIFO_AW    = 3
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         iScanActive,
    input  logic [X_WIDTH-1:0]           iScanCol,
    input  logic [Y_WIDTH-1:0]           iScanRow,
    output logic [DATA_WIDTH-1:0]        oScanData,
    output logic                         oScanDataValid,
    input  logic                         iWrValid,
    input  logic [X_WIDTH-1:0]           iWrCol,
    input  logic [Y_WIDTH-1:0]           iWrRow,
    input  logic [DATA_WIDTH-1:0]        iWrData,
    output logic                         oWrReady,
    output logic                         oWrDrop,
    output logic [FIFO_AW:0]             oFifoLevel,
    output logic [X_WIDTH+Y_WIDTH-1:0]   oRamAddr,
    output logic                         oRamWe,
    output logic [DATA_WIDTH-1:0]        oRamWData,
    input  logic [DATA_WIDTH-1:0]        iRamRData
);

    localparam int unsigned ADDR_W  = X_WIDTH + Y_WIDTH;
    localparam int unsigned LEVEL_W = FIFO_AW + 1;

    typedef struct packed {
        logic [Y_WIDTH-1:0]    row;
        logic [X_WIDTH-1:0]    col;
        logic [DATA_WIDTH-1:0] data;
    } wr_entry_t;

    typedef enum logic [1:0] {
        S_RESET,
        S_IDLE,
        S_SCAN,
        S_WRITE
    } state_t;

    state_t                  state_q,     state_d;
    wr_entry_t               mem_q [FIFO_DEPTH];
    wr_entry_t               mem_d [FIFO_DEPTH];
    logic [FIFO_AW-1:0]      wr_ptr_q,    wr_ptr_d;
    logic [FIFO_AW-1:0]      rd_ptr_q,    rd_ptr_d;
    logic [LEVEL_W-1:0]      level_q,     level_d;
    logic                    wr_ready_q,  wr_ready_d;
    logic [ADDR_W-1:0]       ram_addr_q,  ram_addr_d;
    logic                    ram_we_q,    ram_we_d;
    logic [DATA_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;
    logic                    wr_drop_q,   wr_drop_d;
    logic                    scan_s2_q,   scan_s2_d;
    logic                    scan_vld_q,  scan_vld_d;
    logic [DATA_WIDTH-1:0]   scan_data_q, scan_data_d;

    wr_entry_t               head;
    logic                    push;
    logic                    pop;
    logic                    head_in_range;

    // Arbitration, FIFO bookkeeping and next values of all registered outputs
    always_comb begin
        state_d       = state_q;
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        level_d       = level_q;
        ram_addr_d    = ram_addr_q;
        ram_we_d      = 1'b0;
        ram_wdata_d   = ram_wdata_q;
        wr_drop_d     = 1'b0;
        pop           = 1'b0;
        head          = mem_q[rd_ptr_q];
        push          = iWrValid & wr_ready_q;
        head_in_range = (32'(head.col) < X_SIZE) && (32'(head.row) < Y_SIZE);

        unique case (state_q)
            S_RESET: state_d = S_IDLE;
            S_IDLE, S_SCAN, S_WRITE: begin
                if (iScanActive) begin
                    state_d = S_SCAN;
                end else if (level_q != '0) begin
                    state_d = S_WRITE;
                    pop     = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_SCAN) begin
            ram_addr_d = {iScanRow, iScanCol};
        end

        // An out-of-range head is still popped, but only flagged, never written
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
            if (head_in_range) begin
                ram_we_d    = 1'b1;
                ram_addr_d  = {head.row, head.col};
                ram_wdata_d = head.data;
            end else begin
                wr_drop_d = 1'b1;
            end
        end

        if (push) begin
            mem_d[wr_ptr_q] = '{row: iWrRow, col: iWrCol, data: iWrData};
            wr_ptr_d        = wr_ptr_q + FIFO_AW'(1);
        end

        if (push && !pop) begin
            level_d = level_q + LEVEL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LEVEL_W'(1);
        end

        wr_ready_d  = (level_d < LEVEL_W'(FIFO_DEPTH)) && (state_d != S_RESET);

        // Read pipeline: address out while state is S_SCAN, data back one cycle later
        scan_s2_d   = (state_q == S_SCAN);
        scan_vld_d  = scan_s2_q;
        scan_data_d = scan_s2_q ? iRamRData : scan_data_q;
    end

    // Control and output registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= S_RESET;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            wr_ready_q  <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            wr_drop_q   <= 1'b0;
            scan_s2_q   <= 1'b0;
            scan_vld_q  <= 1'b0;
            scan_data_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            wr_ready_q  <= wr_ready_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            wr_drop_q   <= wr_drop_d;
            scan_s2_q   <= scan_s2_d;
            scan_vld_q  <= scan_vld_d;
            scan_data_q <= scan_data_d;
        end
    end

    // FIFO storage; emptiness is tracked by level/pointers, so no reset needed
    always_ff @(posedge Clock) begin
        mem_q <= mem_d;
    end

    assign oScanData      = scan_data_q;
    assign oScanDataValid = scan_vld_q;
    assign oWrReady       = wr_ready_q;
    assign oWrDrop        = wr_drop_q;
    assign oFifoLevel     = level_q;
    assign oRamAddr       = ram_addr_q;
    assign oRamWe         = ram_we_q;
    assign oRamWData      = ram_wdata_q;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// tb_vga_vram_arbiter: directed and randomized stimulus for vga_vram_arbiter, checked
// cycle by cycle against a queue-based reference model and a behavioural video RAM.
module tb_vga_vram_arbiter;

    localparam int unsigned XW    = 8;
    localparam int unsigned YW    = 8;
    localparam int unsigned XS    = 200;
    localparam int unsigned YS    = 256;
    localparam int unsigned DW    = 3;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned FAW   = 3;

    logic              Clock = 1'b0;
    logic              Reset;
    logic              iScanActive;
    logic [XW-1:0]     iScanCol;
    logic [YW-1:0]     iScanRow;
    logic [DW-1:0]     oScanData;
    logic              oScanDataValid;
    logic              iWrValid;
    logic [XW-1:0]     iWrCol;
    logic [YW-1:0]     iWrRow;
    logic [DW-1:0]     iWrData;
    logic              oWrReady;
    logic              oWrDrop;
    logic [FAW:0]      oFifoLevel;
    logic [XW+YW-1:0]  oRamAddr;
    logic              oRamWe;
    logic [DW-1:0]     oRamWData;
    logic [DW-1:0]     iRamRData;

    always #5 Clock = ~Clock;

    vga_vram_arbiter #(
        .X_WIDTH(XW), .Y_WIDTH(YW), .X_SIZE(XS), .Y_SIZE(YS),
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FIFO_AW(FAW)
    ) dut (
        .Clock(Clock), .Reset(Reset),
        .iScanActive(iScanActive), .iScanCol(iScanCol), .iScanRow(iScanRow),
        .oScanData(oScanData), .oScanDataValid(oScanDataValid),
        .iWrValid(iWrValid), .iWrCol(iWrCol), .iWrRow(iWrRow), .iWrData(iWrData),
        .oWrReady(oWrReady), .oWrDrop(oWrDrop), .oFifoLevel(oFifoLevel),
        .oRamAddr(oRamAddr), .oRamWe(oRamWe), .oRamWData(oRamWData),
        .iRamRData(iRamRData)
    );

    // Power-up RAM contents, a fixed function of the address
    function automatic logic [DW-1:0] init_pix(input logic [15:0] a);
        return a[2:0] ^ a[7:5] ^ a[13:11];
    endfunction

    // Behavioural single-port RAM, one cycle read latency, read-before-write
    logic [DW-1:0] vram [0:65535];
    bit            vwr  [0:65535];
    always @(posedge Clock) begin
        iRamRData <= vwr[oRamAddr] ? vram[oRamAddr] : init_pix(oRamAddr);
        if (oRamWe) begin
            vram[oRamAddr] <= oRamWData;
            vwr[oRamAddr]  <= 1'b1;
        end
    end

    // Reference model state
    typedef struct {
        logic [7:0] row;
        logic [7:0] col;
        logic [2:0] data;
    } ent_t;

    ent_t          mq[$];
    int            due_q[$];
    logic [DW-1:0] dat_q[$];
    logic [DW-1:0] ref_mem [0:65535];
    int            e_level;
    bit            e_ready, e_we, e_drop, e_addr_chk, z_chk, after_rst;
    logic [15:0]   e_addr;
    logic [DW-1:0] e_wdata;
    int            cyc;
    int            n_cmp, n_bad;
    int            n_sv, n_push;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        bit sv_exp;
        chk("fifo_level", 32'(oFifoLevel), 32'(e_level));
        chk("wr_ready", 32'(oWrReady), 32'(e_ready));
        chk("ram_we", 32'(oRamWe), 32'(e_we));
        chk("wr_drop", 32'(oWrDrop), 32'(e_drop));
        sv_exp = (due_q.size() > 0) && (due_q[0] == cyc);
        chk("scan_valid", 32'(oScanDataValid), 32'(sv_exp));
        if (oScanDataValid === 1'b1) n_sv++;
        if (sv_exp) begin
            chk("scan_data", 32'(oScanData), 32'(dat_q[0]));
            void'(due_q.pop_front());
            void'(dat_q.pop_front());
        end
        if (e_addr_chk) chk("ram_addr", 32'(oRamAddr), 32'(e_addr));
        if (e_we)       chk("ram_wdata", 32'(oRamWData), 32'(e_wdata));
        if (z_chk) begin
            chk("rst_scan_data", 32'(oScanData), 32'(0));
            chk("rst_ram_wdata", 32'(oRamWData), 32'(0));
        end
    endtask

    // Predict the registered outputs that follow this cycle's inputs
    task automatic model_update(input bit rst, input bit scan, input logic [7:0] scol,
                                input logic [7:0] srow, input bit wv, input logic [7:0] wcol,
                                input logic [7:0] wrow, input logic [2:0] wd);
        bit   first, push;
        ent_t e;
        if (rst) begin
            mq.delete(); due_q.delete(); dat_q.delete();
            e_level = 0; e_ready = 0; e_we = 0; e_drop = 0;
            e_addr_chk = 1; e_addr = '0; e_wdata = '0; z_chk = 1; after_rst = 1;
            return;
        end
        first = after_rst;
        after_rst = 0; e_we = 0; e_drop = 0; e_addr_chk = 0; z_chk = 0;
        push = wv && e_ready;
        if (!first) begin
            if (scan) begin
                e_addr = {srow, scol};
                e_addr_chk = 1;
                due_q.push_back(cyc + 3);
                dat_q.push_back(ref_mem[{srow, scol}]);
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                if (int'(e.col) < int'(XS) && int'(e.row) < int'(YS)) begin
                    e_we = 1; e_addr = {e.row, e.col}; e_addr_chk = 1; e_wdata = e.data;
                    ref_mem[{e.row, e.col}] = e.data;
                end else begin
                    e_drop = 1;
                end
            end
        end
        if (push) begin
            e.row = wrow; e.col = wcol; e.data = wd;
            mq.push_back(e);
            n_push++;
        end
        e_level = mq.size();
        e_ready = (mq.size() < DEPTH);
    endtask

    // One clock cycle: check outputs, drive inputs, advance the model
    task automatic cycle(input bit rst, input bit scan, input logic [7:0] scol,
                         input logic [7:0] srow, input bit wv, input logic [7:0] wcol,
                         input logic [7:0] wrow, input logic [2:0] wd);
        @(negedge Clock);
        cyc++;
        check_outputs();
        Reset = rst; iScanActive = scan; iScanCol = scol; iScanRow = srow;
        iWrValid = wv; iWrCol = wcol; iWrRow = wrow; iWrData = wd;
        model_update(rst, scan, scol, srow, wv, wcol, wrow, wd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 3'd0);
    endtask

    task automatic scan_wr(input bit wv);
        cycle(0, 1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              wv, 8'($urandom_range(0, XS - 1)), 8'($urandom_range(0, 255)), 3'($urandom));
    endtask

    initial begin
        bit scan_on;
        Reset = 1; iScanActive = 0; iScanCol = '0; iScanRow = '0;
        iWrValid = 0; iWrCol = '0; iWrRow = '0; iWrData = '0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_pix(16'(i));
        mq.delete(); due_q.delete(); dat_q.delete();
        e_level = 0; e_ready = 0; e_we = 0; e_drop = 0; e_addr_chk = 1; e_addr = '0;
        e_wdata = '0; z_chk = 1; after_rst = 1;
        cyc = 0; n_cmp = 0; n_bad = 0; n_sv = 0; n_push = 0;

        // Reset state, then a single in-range write with scan idle
        cycle(1, 0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 3'd0);
        cycle(1, 0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 3'd0);
        idle(2);
        cycle(0, 0, 8'd0, 8'd0, 1, 8'd3, 8'd4, 3'd5);
        idle(4);

        // Full scan line, row 7
        n_sv = 0;
        for (int c = 0; c < 256; c++) cycle(0, 1, 8'(c), 8'd7, 0, 8'd0, 8'd0, 3'd0);
        idle(5);
        chk("scan_line_len", 32'(n_sv), 32'(256));

        // Ten writes offered during scan: only the FIFO depth is accepted
        n_push = 0;
        for (int i = 0; i < 10; i++) scan_wr(1);
        scan_wr(0);
        scan_wr(0);
        chk("burst_accept", 32'(n_push), 32'(DEPTH));
        idle(12);

        // Out-of-range column is dropped
        cycle(0, 0, 8'd0, 8'd0, 1, 8'd210, 8'd1, 3'd6);
        idle(4);

        // Push/pop together at level 3, then scan preempts the drain
        for (int i = 0; i < 3; i++) scan_wr(1);
        cycle(0, 0, 8'd0, 8'd0, 1, 8'd9, 8'd9, 3'd1);
        scan_wr(0);
        scan_wr(0);
        idle(8);

        // Reset while draining five queued entries
        for (int i = 0; i < 5; i++) scan_wr(1);
        idle(2);
        cycle(1, 0, 8'd0, 8'd0, 1, 8'd1, 8'd1, 3'd1);
        cycle(0, 0, 8'd0, 8'd0, 1, 8'd2, 8'd2, 3'd2);
        idle(4);

        // Randomized traffic with occasional resets
        scan_on = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 11) == 0) scan_on = !scan_on;
            cycle(($urandom_range(0, 399) == 0), scan_on && ($urandom_range(0, 7) != 0),
                  8'($urandom), 8'($urandom), ($urandom_range(0, 2) != 0),
                  8'($urandom), 8'($urandom), 3'($urandom));
        end
        idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
